data_bus_master: RTL

// - Load/store bus master between the multicycle CPU datapath and the APB peripheral/data-memory bus.
// - Control unit pulses req in its MEM state with a byte address, a store flag, func3 and raw rs2 data.
// - Block runs one APB transfer: builds byte strobes and lane-aligned write data, then extracts and extends load data.
// - rdata feeds the datapath read-data register. done lets the control unit leave its MEM wait state.

---
 rtl/data_bus_master_if.sv | 23 ++
 rtl/data_bus_master.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/data_bus_master_if.sv
// APB-side signal bundle for the data bus master.
// The master modport drives address/control/write data; the slave returns read data and status.
interface data_bus_master_if;
   logic [31:0] PADDR;
   logic [31:0] PWDATA;
   logic [3:0]  PSTRB;
   logic        PWRITE;
   logic        PSEL;
   logic        PENABLE;
   logic [31:0] PRDATA;
   logic        PREADY;
   logic        PSLVERR;

   modport master (
      output PADDR, PWDATA, PSTRB, PWRITE, PSEL, PENABLE,
      input  PRDATA, PREADY, PSLVERR
   );

   modport slave (
      input  PADDR, PWDATA, PSTRB, PWRITE, PSEL, PENABLE,
      output PRDATA, PREADY, PSLVERR
   );
endinterface

// File: rtl/data_bus_master.sv
// Load/store APB master for the multicycle CPU: one transfer per req, lane steering and load extension.
// Optional ACCESS watchdog enabled by defining DBUS_TIMEOUT_EN (abort after TIMEOUT_CYCLES wait cycles).
module data_bus_master #(
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               req,
   input  logic               we,
   input  logic [2:0]         func3,
   input  logic [31:0]        addr,
   input  logic [31:0]        wdata,
   output logic [31:0]        rdata,
   output logic               done,
   output logic               err,
   output logic               busy,
   data_bus_master_if.master  bus
);

   typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

   state_t      state_reg;
   logic [31:0] paddr_reg;
   logic [31:0] pwdata_reg;
   logic [3:0]  pstrb_reg;
   logic        pwrite_reg;
   logic        psel_reg;
   logic        penable_reg;
   logic [31:0] rdata_reg;
   logic        done_reg;
   logic        err_reg;
   logic [1:0]  off_reg;
   logic [2:0]  func3_reg;

   logic        f3_ok;
   logic        aligned;
   logic [3:0]  pstrb_next;
   logic [31:0] pwdata_next;
   logic [7:0]  load_byte;
   logic [15:0] load_half;
   logic [31:0] load_data;

   if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_timeout_range
      $error("data_bus_master: TIMEOUT_CYCLES must be 1..255");
   end

   // Request legality: width code must exist for the direction, address aligned to the width.
   always_comb begin
      f3_ok   = 1'b0;
      aligned = 1'b1;
      case (func3)
         3'b000: f3_ok = 1'b1;
         3'b001: begin f3_ok = 1'b1; aligned = ~addr[0];          end
         3'b010: begin f3_ok = 1'b1; aligned = (addr[1:0] == 2'b00); end
         3'b100: f3_ok = ~we;
         3'b101: begin f3_ok = ~we;  aligned = ~addr[0];          end
         default: f3_ok = 1'b0;
      endcase
   end

   always_comb begin
      pstrb_next  = 4'b1111;
      pwdata_next = wdata;
      case (func3[1:0])
         2'b00: begin
            pstrb_next  = 4'b0001 << addr[1:0];
            pwdata_next = {4{wdata[7:0]}};
         end
         2'b01: begin
            pstrb_next  = addr[1] ? 4'b1100 : 4'b0011;
            pwdata_next = {2{wdata[15:0]}};
         end
         default: ;
      endcase
      if (!we)
         pstrb_next = 4'b0000;
   end

   assign load_byte = bus.PRDATA[8*off_reg +: 8];
   assign load_half = bus.PRDATA[16*off_reg[1] +: 16];

   always_comb begin
      case (func3_reg)
         3'b000:  load_data = {{24{load_byte[7]}}, load_byte};
         3'b001:  load_data = {{16{load_half[15]}}, load_half};
         3'b100:  load_data = {24'd0, load_byte};
         3'b101:  load_data = {16'd0, load_half};
         default: load_data = bus.PRDATA;
      endcase
   end

`ifdef DBUS_TIMEOUT_EN
   localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);
   logic [7:0] wait_cnt_reg;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg   <= IDLE;
         paddr_reg   <= '0;
         pwdata_reg  <= '0;
         pstrb_reg   <= '0;
         pwrite_reg  <= 1'b0;
         psel_reg    <= 1'b0;
         penable_reg <= 1'b0;
         rdata_reg   <= '0;
         done_reg    <= 1'b0;
         err_reg     <= 1'b0;
         off_reg     <= '0;
         func3_reg   <= '0;
`ifdef DBUS_TIMEOUT_EN
         wait_cnt_reg <= '0;
`endif
      end else begin
         done_reg <= 1'b0;
         err_reg  <= 1'b0;
         case (state_reg)
            IDLE: begin
               if (req) begin
                  if (f3_ok && aligned) begin
                     paddr_reg  <= {addr[31:2], 2'b00};
                     pwdata_reg <= pwdata_next;
                     pstrb_reg  <= pstrb_next;
                     pwrite_reg <= we;
                     off_reg    <= addr[1:0];
                     func3_reg  <= func3;
                     psel_reg   <= 1'b1;
                     state_reg  <= SETUP;
                  end else begin
                     // Rejected request: report it without touching the bus.
                     done_reg <= 1'b1;
                     err_reg  <= 1'b1;
                  end
               end
            end
            SETUP: begin
               penable_reg <= 1'b1;
               state_reg   <= ACCESS;
`ifdef DBUS_TIMEOUT_EN
               wait_cnt_reg <= '0;
`endif
            end
            ACCESS: begin
               if (bus.PREADY) begin
                  psel_reg    <= 1'b0;
                  penable_reg <= 1'b0;
                  done_reg    <= 1'b1;
                  err_reg     <= bus.PSLVERR;
                  if (!pwrite_reg)
                     rdata_reg <= load_data;
                  state_reg   <= IDLE;
               end
`ifdef DBUS_TIMEOUT_EN
               else if (wait_cnt_reg == TIMEOUT_LAST) begin
                  psel_reg    <= 1'b0;
                  penable_reg <= 1'b0;
                  done_reg    <= 1'b1;
                  err_reg     <= 1'b1;
                  state_reg   <= IDLE;
               end else begin
                  wait_cnt_reg <= wait_cnt_reg + 8'd1;
               end
`endif
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

   assign busy        = (state_reg != IDLE);
   assign rdata       = rdata_reg;
   assign done        = done_reg;
   assign err         = err_reg;
   assign bus.PADDR   = paddr_reg;
   assign bus.PWDATA  = pwdata_reg;
   assign bus.PSTRB   = pstrb_reg;
   assign bus.PWRITE  = pwrite_reg;
   assign bus.PSEL    = psel_reg;
   assign bus.PENABLE = penable_reg;

endmodule
